// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical counters,
// registered sync/active/coordinate outputs and a free-running frame counter.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned PIX_DIV     = 2,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        pix_en,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [9:0]  x_cord,
  output logic [8:0]  y_cord,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X_MAX      = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_MAX      = 9'(V_ACTIVE - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt, v_cnt;
  logic [9:0]       h_nxt, v_nxt;
  logic             tick;
  logic             hs_nxt, vs_nxt, act_nxt, ls_nxt, fs_nxt;
  logic [9:0]       x_nxt;
  logic [8:0]       y_nxt;

  // Outputs are decoded from the post-advance counts so the strobe carries
  // the position the counters hold after this tick.
  always_comb begin
    tick    = (div_cnt == DIV_LAST);
    h_nxt   = (h_cnt == H_LAST) ? 10'd0 : h_cnt + 10'd1;
    v_nxt   = v_cnt;
    if (h_cnt == H_LAST) begin
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
    hs_nxt  = ((h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_nxt  = ((v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    x_nxt   = (h_nxt < H_ACT) ? h_nxt : X_MAX;
    y_nxt   = (v_nxt < V_ACT) ? v_nxt[8:0] : Y_MAX;
    ls_nxt  = (h_nxt == 10'd0);
    fs_nxt  = (h_nxt == 10'd0) && (v_nxt == 10'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        h_cnt <= h_nxt;
        v_cnt <= v_nxt;
      end
    end
  end

  // Between strobes the registered outputs hold, so they stay stable while
  // downstream logic samples them under pix_en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_en      <= 1'b0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      active      <= 1'b0;
      x_cord      <= '0;
      y_cord      <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (!enable) begin
      pix_en      <= 1'b0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      active      <= 1'b0;
      x_cord      <= '0;
      y_cord      <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= tick;
      line_start  <= tick && ls_nxt;
      frame_start <= tick && fs_nxt;
      if (tick) begin
        hsync  <= hs_nxt;
        vsync  <= vs_nxt;
        active <= act_nxt;
        x_cord <= x_nxt;
        y_cord <= y_nxt;
        if (fs_nxt) begin
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

endmodule
